iq_mag_sq: RTL
==============

IQ_MAG_SQ -- requirements
Module: iq_mag_sq

Interface
REQ-001 SHALL have parameter W, default 8, signed width of each I and Q input sample.
REQ-002 SHALL have parameter OUT_W, default 2*W, unsigned width of mag_sq; legal range 2 to 2*W, even; equals N of the downstream square-root stage.
REQ-003 SHALL have port Clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_in  input  W  signed in-phase sample.
REQ-006 SHALL have port q_in  input  W  signed quadrature sample.
REQ-007 SHALL have port in_valid  input  1  i_in/q_in hold a sample.
REQ-008 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-009 SHALL have port mag_sq  output  OUT_W  unsigned I^2+Q^2, scaled to the top OUT_W bits of the 2*W-bit sum.
REQ-010 SHALL have port out_valid  output  1  mag_sq holds a result.
REQ-011 SHALL have port out_ready  input  1  downstream accepts mag_sq this cycle.

Function
REQ-012 SHALL implement a 3-stage pipeline: S1 registers |i_in|, |q_in| as W-bit unsigned values; S2 registers both squares; S3 registers the scaled sum and its valid bit.
REQ-013 SHALL compute absolute values so that -2^(W-1) maps to 2^(W-1), with no wrap.
REQ-014 SHALL compute the sum at 2*W bits; the maximum value, 2^(2*W-1), SHALL NOT overflow.
REQ-015 SHALL use one global advance enable, adv = ~out_valid | out_ready; each stage's data and valid bit load only when adv=1.
REQ-016 SHALL drive in_ready = adv combinationally; a sample transfers when in_valid & in_ready.
REQ-017 SHALL give 3 cycles of latency from transfer to out_valid when out_ready is held high, with a throughput of one sample per cycle.
REQ-018 SHALL hold mag_sq and out_valid stable while out_valid=1 and out_ready=0, and SHALL freeze all stages (bubbles included).
REQ-019 SHALL allow a simultaneous transfer and output handshake in the same cycle without losing or duplicating a sample.
REQ-020 SHALL propagate bubbles (valid=0) through the stages; mag_sq is don't-care while out_valid=0 but SHALL NOT change while stalled.
REQ-021 SHALL preserve sample order; no sample is dropped or repeated.

Reset
REQ-022 SHALL, while reset_n=0, clear all stage valid bits and data registers; out_valid=0, mag_sq=0, in_ready=1.
REQ-023 SHALL discard any in-flight samples when reset is asserted mid-operation; the first output after release SHALL come from a sample accepted after release.

Configuration
REQ-024 SHALL support macro IQ_MAG_SQ_ROUND_EN.
REQ-025 SHALL, when IQ_MAG_SQ_ROUND_EN is undefined, truncate: mag_sq = sum[2*W-1 : 2*W-OUT_W].
REQ-026 SHALL, when IQ_MAG_SQ_ROUND_EN is defined and OUT_W<2*W, round half up: add 2^(2*W-OUT_W-1) before truncating; since the sum is at most 2^(2*W-1), no saturation is needed.
REQ-027 SHALL produce identical results with and without the macro when OUT_W=2*W.

Verification
REQ-028 SHALL cover basic values: W=8, OUT_W=16, i=3, q=-4, out_ready=1 -> mag_sq=25 exactly 3 cycles after transfer.
REQ-029 SHALL cover the extreme input: i=-128, q=-128 -> mag_sq=0x8000; with OUT_W=8, truncation and rounding both give 0x80.
REQ-030 SHALL cover rounding: OUT_W=8, i=11, q=0 (sum 121=0x0079) -> truncate gives 0x00, IQ_MAG_SQ_ROUND_EN gives 0x00; i=12 (sum 144=0x0090) -> truncate gives 0x00, round gives 0x01.
REQ-031 SHALL cover backpressure: stream 1..6 as (i,q)=(k,0), out_ready low for 4 cycles mid-stream -> in_ready low while out_valid=1, outputs 1,4,9,16,25,36 in order, none duplicated.
REQ-032 SHALL cover reset mid-stream: reset_n pulsed low with 2 samples in flight -> out_valid=0 immediately; after release, the first output is the first new sample.
REQ-033 SHALL cover random streaming: random in_valid/out_ready over 10,000 samples checked against a reference model, with zero mismatches and zero order errors.

Source files
------------

// File: rtl/iq_mag_sq.sv
// -----------------------------------------------------------------------------
// iq_mag_sq
//
// Purpose:
//   Three-stage pipelined squared magnitude of a complex sample, I^2 + Q^2,
//   with valid/ready handshaking on both sides. The result is scaled to the
//   top OUT_W bits of the full 2*W-bit sum so it can feed a square-root stage
//   of width OUT_W directly.
//
//   Stage 1 : |i_in|, |q_in| as W-bit unsigned values
//   Stage 2 : both squares (2*W bits each)
//   Stage 3 : scaled sum and its valid bit (drives mag_sq / out_valid)
//
//   A single advance enable (adv = ~out_valid | out_ready) moves every stage
//   at once, so a stalled output freezes the whole pipe, bubbles included.
//
// Parameters:
//   W      signed width of each I/Q sample (default 8)
//   OUT_W  unsigned width of mag_sq, even, 2..2*W (default 2*W)
//
// Ports:
//   Clock      in   rising-edge clock for all state
//   reset_n    in   asynchronous, active-low reset
//   i_in       in   W      signed in-phase sample
//   q_in       in   W      signed quadrature sample
//   in_valid   in   1      i_in/q_in hold a sample
//   in_ready   out  1      sample accepted this cycle when in_valid is high
//   mag_sq     out  OUT_W  unsigned I^2+Q^2, top OUT_W bits of the sum
//   out_valid  out  1      mag_sq holds a result
//   out_ready  in   1      downstream takes mag_sq this cycle
//
// Configuration:
//   IQ_MAG_SQ_ROUND_EN  when defined (and OUT_W < 2*W) the dropped low bits
//                       are rounded half-up instead of truncated.
// -----------------------------------------------------------------------------
module iq_mag_sq #(
    parameter int W     = 8,
    parameter int OUT_W = 2 * W
) (
    input  logic                Clock,
    input  logic                reset_n,
    input  logic signed [W-1:0] i_in,
    input  logic signed [W-1:0] q_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [OUT_W-1:0]    mag_sq,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int SW   = 2 * W;       // full-precision sum width
    localparam int DROP = SW - OUT_W;  // low bits discarded by the scaling

    logic adv;

    // Lane 0 carries I, lane 1 carries Q.
    logic [1:0][W-1:0]  samp;
    logic [1:0][W-1:0]  abs_c;
    logic [1:0][W-1:0]  abs_d,  abs_q;
    logic [1:0][SW-1:0] sq_c;
    logic [1:0][SW-1:0] sq_d,   sq_q;
    logic               v1_d,   v1_q;
    logic               v2_d,   v2_q;
    logic               v3_d,   v3_q;
    logic [SW-1:0]      sum_c;
    logic [SW-1:0]      sum_adj;
    logic [OUT_W-1:0]   mag_d,  mag_q;

    assign adv      = ~v3_q | out_ready;
    assign in_ready = adv;
    assign samp     = {q_in, i_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            // Two's-complement negate in W unsigned bits: the most negative
            // value -2^(W-1) becomes 2^(W-1), which still fits unsigned.
            assign abs_c[gi] = samp[gi][W-1]
                             ? (~samp[gi]) + {{(W-1){1'b0}}, 1'b1}
                             : samp[gi];
            assign sq_c[gi]  = SW'(abs_q[gi]) * SW'(abs_q[gi]);
        end
    endgenerate

    // Each square is at most 2^(2W-2), so the sum tops out at 2^(2W-1) and
    // never carries out of SW bits.
    assign sum_c = sq_q[0] + sq_q[1];

    generate
        if (DROP == 0) begin : g_full
            assign sum_adj = sum_c;
        end else begin : g_scaled
`ifdef IQ_MAG_SQ_ROUND_EN
            // Half-LSB bias before truncation; the sum ceiling leaves room
            // for it, so no saturation is required.
            assign sum_adj = sum_c + (SW'(1) << (DROP - 1));
`else
            assign sum_adj = sum_c;
`endif
        end
    endgenerate

    always_comb begin
        abs_d = abs_q;
        sq_d  = sq_q;
        mag_d = mag_q;
        v1_d  = v1_q;
        v2_d  = v2_q;
        v3_d  = v3_q;
        if (adv) begin
            abs_d = abs_c;
            v1_d  = in_valid;
            sq_d  = sq_c;
            v2_d  = v1_q;
            mag_d = sum_adj[SW-1:DROP];
            v3_d  = v2_q;
        end
    end

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            abs_q <= '0;
            sq_q  <= '0;
            mag_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
        end else begin
            abs_q <= abs_d;
            sq_q  <= sq_d;
            mag_q <= mag_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
        end
    end

    assign mag_sq    = mag_q;
    assign out_valid = v3_q;

endmodule
